// File: rtl/data_memory_pkg.sv
// Shared widths, the memory word type and the byte-address decoder for data_memory.
package data_memory_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 32;
  // Widest byte address the decoder accepts; narrower addresses are zero-extended.
  localparam int MAX_ADDR_WIDTH = 64;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;

  typedef struct packed {
    logic [MAX_ADDR_WIDTH-1:0] index;
    logic                      in_range;
  } decode_t;

  // Word index drops the two byte-offset bits; anything above the index field
  // being non-zero means the access falls outside the array.
  function automatic decode_t decode_addr(input logic [MAX_ADDR_WIDTH-1:0] addr,
                                          input int unsigned               index_bits);
    decode_t                   d;
    logic [MAX_ADDR_WIDTH-1:0] mask;
    mask       = (MAX_ADDR_WIDTH'(1) << index_bits) - MAX_ADDR_WIDTH'(1);
    d.index    = (addr >> 2) & mask;
    d.in_range = (addr >> (index_bits + 2)) == '0;
    return d;
  endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Word register array: synchronous clear, one synchronous write port and one
// asynchronous read port.
module dmem_word_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int INDEX_BITS = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [INDEX_BITS-1:0] index,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the whole array is cleared on reset because loads must never return X
  // after the first reset; this rules out block-RAM mapping, which is accepted here.
  // NOTE: non-blocking assignments keep the array update race-free against the
  // combinational read below within the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_en) begin
      mem[index] <= write_data;
    end
  end

  assign read_data = mem[index];

endmodule

// File: rtl/data_memory.sv
// Data memory for the memory stage: address decode, read gating and write enable
// around dmem_word_array. Define DATA_MEMORY_ERR_EN to add the error output.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memwrite,
  input  logic                  memread,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writedata,
`ifdef DATA_MEMORY_ERR_EN
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  error
`else
  output logic [DATA_WIDTH-1:0] readdata
`endif
);

  localparam int INDEX_BITS = $clog2(DEPTH);

  decode_t               dec;
  logic                  access_ok;
  logic                  write_en;
  logic [DATA_WIDTH-1:0] array_data;
  logic                  unused_index_hi;

  always_comb begin
    dec = decode_addr(MAX_ADDR_WIDTH'(address), INDEX_BITS);
  end

  // The decoder masks the index, so its upper bits are always zero.
  assign unused_index_hi = ^dec.index[MAX_ADDR_WIDTH-1:INDEX_BITS];

`ifdef DATA_MEMORY_ERR_EN
  logic misaligned;
  assign misaligned = address[1:0] != 2'b00;
  assign error      = (memread | memwrite) & (misaligned | ~dec.in_range);
  assign access_ok  = dec.in_range & ~misaligned;
`else
  // Byte offset is ignored: misaligned accesses hit the containing word.
  assign access_ok = dec.in_range;
`endif

  assign write_en = memwrite & access_ok;

  dmem_word_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .INDEX_BITS(INDEX_BITS)
  ) u_array (
    .clock     (clock),
    .reset     (reset),
    .write_en  (write_en),
    .index     (dec.index[INDEX_BITS-1:0]),
    .write_data(writedata),
    .read_data (array_data)
  );

  // NOTE: readdata is assigned on every path so this stays combinational (no latch).
  always_comb begin
    readdata = '0;
    if (memread && access_ok) begin
      readdata = array_data;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: expected words are queued as stimulus is
// driven and popped when readdata is sampled. Honours DATA_MEMORY_ERR_EN.
module tb_data_memory;
  import data_memory_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        memwrite;
  logic        memread;
  logic [31:0] address;
  word_t       writedata;
  word_t       readdata;
`ifdef DATA_MEMORY_ERR_EN
  logic        error;
`endif

  int    total = 0;
  int    bad   = 0;
  word_t exp_q[$];
  word_t exp;

  data_memory dut (
    .clock    (clock),
    .reset    (reset),
    .memwrite (memwrite),
    .memread  (memread),
    .address  (address),
    .writedata(writedata),
`ifdef DATA_MEMORY_ERR_EN
    .readdata (readdata),
    .error    (error)
`else
    .readdata (readdata)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic set_inputs(input logic w, input logic r, input logic [31:0] a, input word_t d);
    @(negedge clock);
    memwrite  = w;
    memread   = r;
    address   = a;
    writedata = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_inputs(1'b0, 1'b0, 32'h0, '0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_inputs(1'b0, 1'b1, 32'(i * 4), '0);
      exp_q.push_back(32'h0);
      exp = exp_q.pop_front();
      total++;
      if (readdata !== exp) begin
        bad++;
        $display("FAIL reset_clear addr=%0h got=%h want=%h", address, readdata, exp);
      end
    end
  endtask

  task automatic test_write_read();
    set_inputs(1'b1, 1'b0, 32'h0, 32'hAAAA_BBBB);
    exp_q.push_back(32'hAAAA_BBBB);
    tick();
    set_inputs(1'b1, 1'b0, 32'h4, 32'h1234_5678);
    exp_q.push_back(32'h1234_5678);
    tick();
    for (int i = 0; i < 2; i++) begin
      set_inputs(1'b0, 1'b1, 32'(i * 4), '0);
      exp = exp_q.pop_front();
      total++;
      if (readdata !== exp) begin
        bad++;
        $display("FAIL write_read addr=%0h got=%h want=%h", address, readdata, exp);
      end
    end
  endtask

  task automatic test_dropped_write();
    set_inputs(1'b1, 1'b0, 32'h4, 32'h1234_5678);
    set_inputs(1'b0, 1'b0, 32'h8, 32'hDEAD_BEEF);
    tick();
    set_inputs(1'b0, 1'b1, 32'h8, '0);
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front();
    total++;
    if (readdata !== exp) begin
      bad++;
      $display("FAIL dropped_write addr=8 got=%h want=%h", readdata, exp);
    end
    set_inputs(1'b0, 1'b1, 32'h4, '0);
    exp_q.push_back(32'h1234_5678);
    exp = exp_q.pop_front();
    total++;
    if (readdata !== exp) begin
      bad++;
      $display("FAIL dropped_write addr=4 got=%h want=%h", readdata, exp);
    end
  endtask

  task automatic test_read_gate();
    set_inputs(1'b0, 1'b0, 32'h0, '0);
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front();
    total++;
    if (readdata !== exp) begin
      bad++;
      $display("FAIL read_gate_off got=%h want=%h", readdata, exp);
    end
    memread = 1'b1;
    #1;
    exp_q.push_back(32'hAAAA_BBBB);
    exp = exp_q.pop_front();
    total++;
    if (readdata !== exp) begin
      bad++;
      $display("FAIL read_gate_on got=%h want=%h", readdata, exp);
    end
  endtask

  task automatic test_write_during_read();
    set_inputs(1'b1, 1'b1, 32'h4, 32'hCAFE_F00D);
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'hCAFE_F00D);
    exp = exp_q.pop_front();
    total++;
    if (readdata !== exp) begin
      bad++;
      $display("FAIL rw_before_edge got=%h want=%h", readdata, exp);
    end
    tick();
    exp = exp_q.pop_front();
    total++;
    if (readdata !== exp) begin
      bad++;
      $display("FAIL rw_after_edge got=%h want=%h", readdata, exp);
    end
    set_inputs(1'b0, 1'b0, 32'h4, '0);
  endtask

  task automatic test_out_of_range();
    logic [31:0] oor_addr [2];
    oor_addr[0] = 32'h0000_0400;
    oor_addr[1] = 32'h8000_0000;
    for (int i = 0; i < 2; i++) begin
      set_inputs(1'b1, 1'b1, oor_addr[i], 32'h1111_1111);
      exp_q.push_back(32'h0);
      exp = exp_q.pop_front();
      total++;
      if (readdata !== exp) begin
        bad++;
        $display("FAIL oor_read addr=%h got=%h want=%h", address, readdata, exp);
      end
`ifdef DATA_MEMORY_ERR_EN
      total++;
      if (error !== 1'b1) begin
        bad++;
        $display("FAIL oor_error addr=%h got=%b want=1", address, error);
      end
`endif
      tick();
    end
    set_inputs(1'b0, 1'b1, 32'h0, '0);
    exp_q.push_back(32'hAAAA_BBBB);
    exp = exp_q.pop_front();
    total++;
    if (readdata !== exp) begin
      bad++;
      $display("FAIL oor_no_alias got=%h want=%h", readdata, exp);
    end
  endtask

  task automatic test_misaligned();
`ifdef DATA_MEMORY_ERR_EN
    set_inputs(1'b0, 1'b1, 32'h4, '0);
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL aligned_error got=%b want=0", error);
    end
    set_inputs(1'b0, 1'b0, 32'h6, '0);
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL idle_error got=%b want=0", error);
    end
`endif
    set_inputs(1'b0, 1'b1, 32'h6, '0);
`ifdef DATA_MEMORY_ERR_EN
    exp_q.push_back(32'h0);
    total++;
    if (error !== 1'b1) begin
      bad++;
      $display("FAIL misaligned_error got=%b want=1", error);
    end
`else
    exp_q.push_back(32'hCAFE_F00D);
`endif
    exp = exp_q.pop_front();
    total++;
    if (readdata !== exp) begin
      bad++;
      $display("FAIL misaligned_read addr=6 got=%h want=%h", readdata, exp);
    end
    set_inputs(1'b1, 1'b0, 32'h2, 32'h5555_5555);
    tick();
    set_inputs(1'b0, 1'b1, 32'h0, '0);
`ifdef DATA_MEMORY_ERR_EN
    exp_q.push_back(32'hAAAA_BBBB);
`else
    exp_q.push_back(32'h5555_5555);
`endif
    exp = exp_q.pop_front();
    total++;
    if (readdata !== exp) begin
      bad++;
      $display("FAIL misaligned_write word0 got=%h want=%h", readdata, exp);
    end
  endtask

  task automatic test_back_to_back();
    word_t data;
    for (int i = 0; i < 8; i++) begin
      data = word_t'($urandom);
      set_inputs(1'b1, 1'b0, 32'(32'h100 + i * 4), data);
      exp_q.push_back(data);
      tick();
    end
    // The top word of the array sits just below the out-of-range boundary.
    set_inputs(1'b1, 1'b0, 32'h3FC, 32'h0F0F_F0F0);
    tick();
    for (int i = 0; i < 8; i++) begin
      set_inputs(1'b0, 1'b1, 32'(32'h100 + i * 4), '0);
      exp = exp_q.pop_front();
      total++;
      if (readdata !== exp) begin
        bad++;
        $display("FAIL b2b addr=%h got=%h want=%h", address, readdata, exp);
      end
    end
    set_inputs(1'b0, 1'b1, 32'h3FC, '0);
    exp_q.push_back(32'h0F0F_F0F0);
    exp = exp_q.pop_front();
    total++;
    if (readdata !== exp) begin
      bad++;
      $display("FAIL top_word got=%h want=%h", readdata, exp);
    end
  endtask

  task automatic test_reset_priority();
    word_t old_word0;
`ifdef DATA_MEMORY_ERR_EN
    old_word0 = 32'hAAAA_BBBB;
`else
    old_word0 = 32'h5555_5555;
`endif
    set_inputs(1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF);
    reset = 1'b1;
    #1;
    exp_q.push_back(old_word0);
    exp = exp_q.pop_front();
    total++;
    if (readdata !== exp) begin
      bad++;
      $display("FAIL rst_before_edge got=%h want=%h", readdata, exp);
    end
    tick();
    reset = 1'b0;
    set_inputs(1'b0, 1'b1, 32'h0, '0);
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front();
    total++;
    if (readdata !== exp) begin
      bad++;
      $display("FAIL rst_priority word0 got=%h want=%h", readdata, exp);
    end
    set_inputs(1'b0, 1'b1, 32'h100, '0);
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front();
    total++;
    if (readdata !== exp) begin
      bad++;
      $display("FAIL rst_clears_all addr=100 got=%h want=%h", readdata, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    memwrite  = 1'b0;
    memread   = 1'b0;
    address   = '0;
    writedata = '0;
    test_reset();
    test_write_read();
    test_dropped_write();
    test_read_gate();
    test_write_during_read();
    test_out_of_range();
    test_misaligned();
    test_back_to_back();
    test_reset_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
